// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Brief    : Shared types, forwarding-select encodings and FSM state codes
//            for the 5-stage pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Architectural register index (r0..r31)
    typedef logic [4:0] reg_idx_t;

    // Operand forwarding mux select
    typedef logic [1:0] fwd_sel_t;

    // Same encoding as the existing 3-input EX operand mux
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b01;

    // Mult/div sequencer states
    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_RUN  = 1'b1;

    // Data-memory wait states
    localparam logic [0:0] M_IDLE  = 1'b0;
    localparam logic [0:0] M_WAIT  = 1'b1;

    // A later stage that may produce a result to forward
    typedef struct packed {
        logic     regwrite;
        reg_idx_t dst;
    } wb_src_t;

    // Pick the youngest producer of src; r0 is never forwarded because it
    // is hardwired to zero in the register file.
    function automatic fwd_sel_t fwd_select(
        input wb_src_t  mem_src,
        input wb_src_t  wb_src,
        input reg_idx_t src
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (mem_src.regwrite && (mem_src.dst != 5'd0) && (mem_src.dst == src)) begin
            sel = FWD_MEM;
        end else if (wb_src.regwrite && (wb_src.dst != 5'd0) && (wb_src.dst == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Brief    : Bundle of pipeline-status inputs and stall/flush/forward
//            controls exchanged between the datapath and hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    // Register operands per stage
    reg_idx_t rsD;
    reg_idx_t rtD;
    reg_idx_t rsE;
    reg_idx_t rtE;
    reg_idx_t writeregE;
    reg_idx_t writeregM;
    reg_idx_t writeregW;
    logic     regwriteE;
    logic     regwriteM;
    logic     regwriteW;

    // Instruction class / event flags
    logic     memtoregE;
    logic     pcsrcE;
    logic     mdstartE;
    logic     memreqM;
    logic     memreadyM;

    // Pipeline register controls
    logic     stallF;
    logic     stallD;
    logic     stallE;
    logic     stallM;
    logic     flushD;
    logic     flushE;
    logic     flushW;

    // Forwarding selects
    fwd_sel_t forwardAE;
    fwd_sel_t forwardBE;

    // Status
    logic     md_busy;
    logic     md_done;
    logic     mem_timeout;

    // Datapath side: reports pipeline contents, consumes controls
    modport master (
        output rsD, rtD, rsE, rtE,
        output writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW,
        output memtoregE, pcsrcE, mdstartE, memreqM, memreadyM,
        input  stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushW,
        input  forwardAE, forwardBE,
        input  md_busy, md_done, mem_timeout
    );

    // Hazard controller side
    modport slave (
        input  rsD, rtD, rsE, rtE,
        input  writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW,
        input  memtoregE, pcsrcE, mdstartE, memreqM, memreadyM,
        output stallF, stallD, stallE, stallM,
        output flushD, flushE, flushW,
        output forwardAE, forwardBE,
        output md_busy, md_done, mem_timeout
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_mem_wait_fsm
// Brief    : Data-memory wait-state sequencer. Holds the pipeline while a
//            MEM-stage access is outstanding and abandons it after
//            MEM_TIMEOUT wait cycles, raising a sticky timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl_mem_wait_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_memreq,
    input  logic i_memready,
    output logic o_mem_stall,
    output logic o_mem_timeout
);

    localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;
    logic       w_stall;

    // Next-state, wait-count and stall decode for the memory wait sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_timeout;
        w_stall        = 1'b0;
        if (r_state == M_IDLE) begin
            // An access that completes immediately never stalls
            if (i_memreq && !i_memready) begin
                w_stall        = 1'b1;
                w_state_nxt    = M_WAIT;
                w_wait_cnt_nxt = 8'd1;
            end
        end else begin
            if (i_memready) begin
                // Release in the ready cycle so MEM/WB captures the data now
                w_state_nxt    = M_IDLE;
                w_wait_cnt_nxt = 8'd0;
            end else if (r_wait_cnt >= c_timeout) begin
                // Give up: let the pipeline move on and flag the error
                w_timeout_nxt  = 1'b1;
                w_state_nxt    = M_IDLE;
                w_wait_cnt_nxt = 8'd0;
            end else begin
                w_stall        = 1'b1;
                w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
        end
    end

    // State, counter and sticky timeout registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= M_IDLE;
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Stall is suppressed while reset is asserted even though inputs may be live
    assign o_mem_stall   = w_stall & reset;
    assign o_mem_timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Central hazard/sequencing controller for the 5-stage pipeline:
//            EX operand forwarding, load-use interlock, branch flush,
//            multi-cycle mult/div sequencing and memory wait states.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_CYCLES   = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [3:0] c_md_load = 4'(MD_CYCLES - 1);

    logic       w_mem_stall;
    logic       w_mem_timeout;

    logic [0:0] r_md_state;
    logic [0:0] w_md_state_nxt;
    logic [3:0] r_md_cnt;
    logic [3:0] w_md_cnt_nxt;
    logic       w_md_stall;
    logic       w_md_done;

    logic       w_load_use;
    logic       w_hold_e;
    logic       w_lu_stall;
    wb_src_t    w_mem_src;
    wb_src_t    w_wb_src;

    // ------------------------------------------------------------------
    // Operand forwarding: MEM result is younger, so it wins over WB
    // ------------------------------------------------------------------
    assign w_mem_src    = {hz.regwriteM, hz.writeregM};
    assign w_wb_src     = {hz.regwriteW, hz.writeregW};
    assign hz.forwardAE = fwd_select(w_mem_src, w_wb_src, hz.rsE);
    assign hz.forwardBE = fwd_select(w_mem_src, w_wb_src, hz.rtE);

    // ------------------------------------------------------------------
    // Memory wait sequencer
    // ------------------------------------------------------------------
    pipeline_hazard_ctrl_mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait (
        .clk           (clk),
        .reset         (reset),
        .i_memreq      (hz.memreqM),
        .i_memready    (hz.memreadyM),
        .o_mem_stall   (w_mem_stall),
        .o_mem_timeout (w_mem_timeout)
    );

    // ------------------------------------------------------------------
    // Mult/div sequencer: the op occupies EX for MD_CYCLES cycles, the last
    // of which releases the stall. Progress freezes while memory holds the
    // pipeline so the op is not counted down under a stalled EX register.
    // ------------------------------------------------------------------

    // Mult/div next-state, count and stall decode
    always_comb begin
        w_md_state_nxt = r_md_state;
        w_md_cnt_nxt   = r_md_cnt;
        w_md_stall     = 1'b0;
        w_md_done      = 1'b0;
        if (r_md_state == MD_IDLE) begin
            if (hz.mdstartE) begin
                w_md_stall = 1'b1;
                if (!w_mem_stall) begin
                    w_md_state_nxt = MD_RUN;
                    w_md_cnt_nxt   = c_md_load;
                end
            end
        end else begin
            if (r_md_cnt > 4'd1) begin
                w_md_stall = 1'b1;
                if (!w_mem_stall) begin
                    w_md_cnt_nxt = r_md_cnt - 4'd1;
                end
            end else if (!w_mem_stall) begin
                // Final cycle: result is ready, EX may advance
                w_md_done      = 1'b1;
                w_md_state_nxt = MD_IDLE;
                w_md_cnt_nxt   = 4'd0;
            end
        end
    end

    // Mult/div state and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_state <= MD_IDLE;
            r_md_cnt   <= 4'd0;
        end else begin
            r_md_state <= w_md_state_nxt;
            r_md_cnt   <= w_md_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Load-use interlock and stall/flush priority
    // ------------------------------------------------------------------
    assign w_load_use = hz.memtoregE && hz.regwriteE && (hz.writeregE != 5'd0) &&
                        ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));

    // Memory or mult/div holding EX; flushes must not clear held registers
    assign w_hold_e   = w_mem_stall | w_md_stall;

    // A taken branch squashes the dependent instruction, so no interlock needed
    assign w_lu_stall = w_load_use & ~hz.pcsrcE & ~w_hold_e;

    assign hz.stallF      = reset & (w_hold_e | w_lu_stall);
    assign hz.stallD      = reset & (w_hold_e | w_lu_stall);
    assign hz.stallE      = reset & w_hold_e;
    assign hz.stallM      = reset & w_mem_stall;
    assign hz.flushD      = reset & ~w_hold_e & hz.pcsrcE;
    assign hz.flushE      = reset & ~w_hold_e & (hz.pcsrcE | w_load_use);
    assign hz.flushW      = reset & w_mem_stall;
    assign hz.md_busy     = (r_md_state == MD_RUN);
    assign hz.md_done     = reset & w_md_done;
    assign hz.mem_timeout = w_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int c_md_cycles   = 4;
    localparam int c_mem_timeout = 16;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .MD_CYCLES   (c_md_cycles),
        .MEM_TIMEOUT (c_mem_timeout)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector order: {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE, hz.flushW};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive just after the active edge, sample on the falling edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
        hz.writeregE = '0; hz.writeregM = '0; hz.writeregW = '0;
        hz.regwriteE = 1'b0; hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
        hz.memtoregE = 1'b0; hz.pcsrcE = 1'b0; hz.mdstartE = 1'b0;
        hz.memreqM = 1'b0; hz.memreadyM = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_inputs();
        reset = 1'b0;

        // ---- Reset: live hazards must not reach the outputs ----
        @(posedge clk);
        #2;
        hz.memreqM = 1'b1; hz.mdstartE = 1'b1; hz.pcsrcE = 1'b1;
        hz.memtoregE = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd5; hz.rtD = 5'd5;
        #1;
        chk_ctl("rst_ctl", 7'b0000000);
        chk1("rst_md_busy", hz.md_busy, 1'b0);
        chk1("rst_md_done", hz.md_done, 1'b0);
        chk1("rst_timeout", hz.mem_timeout, 1'b0);
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;

        // ---- Forwarding ----
        nxt();
        hz.regwriteM = 1'b1; hz.writeregM = 5'd8; hz.regwriteW = 1'b1; hz.writeregW = 5'd8;
        hz.rsE = 5'd8; hz.rtE = 5'd8;
        smp();
        chk2("fwdA_mem_prio", hz.forwardAE, 2'b10);
        chk2("fwdB_mem_prio", hz.forwardBE, 2'b10);
        nxt();
        hz.writeregM = 5'd9;
        smp();
        chk2("fwdA_wb", hz.forwardAE, 2'b01);
        chk2("fwdB_wb", hz.forwardBE, 2'b01);
        nxt();
        hz.writeregM = 5'd0; hz.writeregW = 5'd0;
        smp();
        chk2("fwdA_none", hz.forwardAE, 2'b00);
        nxt();
        hz.rsE = 5'd0; hz.rtE = 5'd0;
        smp();
        chk2("fwdA_r0", hz.forwardAE, 2'b00);
        chk2("fwdB_r0", hz.forwardBE, 2'b00);
        nxt();
        hz.rsE = 5'd3; hz.rtE = 5'd8; hz.writeregM = 5'd8; hz.writeregW = 5'd3;
        smp();
        chk2("fwdA_split_wb", hz.forwardAE, 2'b01);
        chk2("fwdB_split_mem", hz.forwardBE, 2'b10);
        nxt();
        hz.regwriteM = 1'b0; hz.writeregM = 5'd3;
        smp();
        chk2("fwdA_no_regwr_mem", hz.forwardAE, 2'b01);
        chk2("fwdB_no_match", hz.forwardBE, 2'b00);
        clear_inputs();

        // ---- Load-use ----
        nxt();
        hz.memtoregE = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd5; hz.rtD = 5'd5;
        smp();
        chk_ctl("lu_rt_stall", 7'b1100010);
        nxt();
        hz.memtoregE = 1'b0; hz.regwriteE = 1'b0; hz.writeregE = 5'd0;
        smp();
        chk_ctl("lu_one_bubble", 7'b0000000);
        nxt();
        hz.memtoregE = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd7; hz.rsD = 5'd7; hz.rtD = 5'd0;
        smp();
        chk_ctl("lu_rs_stall", 7'b1100010);
        nxt();
        hz.writeregE = 5'd0; hz.rsD = 5'd0;
        smp();
        chk_ctl("lu_r0_ignored", 7'b0000000);
        nxt();
        hz.writeregE = 5'd5; hz.rtD = 5'd5; hz.pcsrcE = 1'b1;
        smp();
        chk_ctl("lu_branch_override", 7'b0000110);
        clear_inputs();

        // ---- Mult/div, MD_CYCLES = 4 ----
        nxt();
        hz.mdstartE = 1'b1;
        smp();
        chk_ctl("md_c0", 7'b1110000);
        chk1("md_c0_busy", hz.md_busy, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            nxt();
            smp();
            chk_ctl("md_run_stall", 7'b1110000);
            chk1("md_run_busy", hz.md_busy, 1'b1);
            chk1("md_run_done", hz.md_done, 1'b0);
        end
        nxt();
        smp();
        chk_ctl("md_c3_release", 7'b0000000);
        chk1("md_c3_busy", hz.md_busy, 1'b1);
        chk1("md_c3_done", hz.md_done, 1'b1);
        nxt();
        hz.mdstartE = 1'b0;
        smp();
        chk1("md_c4_busy", hz.md_busy, 1'b0);
        chk1("md_c4_done", hz.md_done, 1'b0);

        // ---- Memory wait, pending branch held off until release ----
        nxt();
        hz.memreqM = 1'b1; hz.memreadyM = 1'b0; hz.pcsrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk_ctl("mem_wait_stall", 7'b1111001);
            nxt();
        end
        hz.memreadyM = 1'b1;
        smp();
        chk_ctl("mem_ready_release", 7'b0000110);
        nxt();
        hz.memreqM = 1'b0; hz.memreadyM = 1'b0; hz.pcsrcE = 1'b0;
        smp();
        chk_ctl("mem_idle", 7'b0000000);
        nxt();
        hz.memreqM = 1'b1; hz.memreadyM = 1'b1;
        smp();
        chk_ctl("mem_zero_wait", 7'b0000000);
        nxt();
        hz.memreqM = 1'b0; hz.memreadyM = 1'b0;

        // ---- Timeout, MEM_TIMEOUT = 16 ----
        nxt();
        hz.memreqM = 1'b1;
        for (int i = 0; i < c_mem_timeout; i++) begin
            smp();
            chk_ctl("to_wait_stall", 7'b1111001);
            chk1("to_wait_flag", hz.mem_timeout, 1'b0);
            nxt();
        end
        smp();
        chk_ctl("to_release", 7'b0000000);
        nxt();
        hz.memreqM = 1'b0;
        smp();
        chk1("to_flag_set", hz.mem_timeout, 1'b1);
        nxt();
        hz.memreqM = 1'b1;
        smp();
        chk_ctl("to_new_access_stall", 7'b1111001);
        chk1("to_flag_sticky", hz.mem_timeout, 1'b1);
        nxt();
        hz.memreadyM = 1'b1;
        smp();
        chk_ctl("to_new_access_done", 7'b0000000);
        nxt();
        hz.memreqM = 1'b0; hz.memreadyM = 1'b0;
        smp();
        #2;
        reset = 1'b0;
        #1;
        chk1("to_flag_cleared", hz.mem_timeout, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // ---- Memory wait inside a mult/div op freezes the md count ----
        nxt();
        hz.mdstartE = 1'b1;
        smp();
        chk_ctl("ov_c0", 7'b1110000);
        nxt();
        hz.memreqM = 1'b1; hz.memreadyM = 1'b0;
        smp();
        chk_ctl("ov_c1_mem", 7'b1111001);
        chk1("ov_c1_busy", hz.md_busy, 1'b1);
        nxt();
        smp();
        chk_ctl("ov_c2_mem", 7'b1111001);
        nxt();
        hz.memreadyM = 1'b1;
        smp();
        chk_ctl("ov_c3_md_only", 7'b1110000);
        chk1("ov_c3_done", hz.md_done, 1'b0);
        nxt();
        hz.memreqM = 1'b0; hz.memreadyM = 1'b0;
        smp();
        chk_ctl("ov_c4_md_only", 7'b1110000);
        chk1("ov_c4_done", hz.md_done, 1'b0);
        nxt();
        smp();
        chk_ctl("ov_c5_release", 7'b0000000);
        chk1("ov_c5_done", hz.md_done, 1'b1);
        nxt();
        hz.mdstartE = 1'b0;
        smp();
        chk1("ov_c6_busy", hz.md_busy, 1'b0);

        // ---- Reset during M_WAIT with md running ----
        nxt();
        hz.mdstartE = 1'b1;
        smp();
        chk_ctl("rw_c0", 7'b1110000);
        nxt();
        hz.memreqM = 1'b1; hz.memreadyM = 1'b0;
        smp();
        chk_ctl("rw_c1", 7'b1111001);
        nxt();
        smp();
        chk_ctl("rw_c2_wait", 7'b1111001);
        chk1("rw_c2_busy", hz.md_busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_ctl("rw_async_ctl", 7'b0000000);
        chk1("rw_async_busy", hz.md_busy, 1'b0);
        hz.memreqM = 1'b0; hz.mdstartE = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        nxt();
        smp();
        chk_ctl("rw_mem_idle", 7'b0000000);
        chk1("rw_md_idle", hz.md_busy, 1'b0);
        nxt();
        hz.mdstartE = 1'b1;
        smp();
        chk_ctl("rw_md_restart", 7'b1110000);
        chk1("rw_md_restart_busy", hz.md_busy, 1'b0);
        nxt();
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage MIPS pipeline.
- Drives the stall inputs of the pipeline registers (held while stall=1) and the clear (bubble) inputs.
- Drives the 2-bit select of the EX-stage operand forwarding muxes.
- Sequences multi-cycle multiply/divide ops in EX and data-memory wait states in MEM.

Parameters:
- MD_CYCLES, 4, total cycles a mult/div op occupies EX (legal range 2..15).
- MEM_TIMEOUT, 16, maximum WAIT cycles before the memory access is abandoned (legal range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rsD, rtD  in  5 each  source registers in ID.
- rsE, rtE  in  5 each  source registers in EX.
- writeregE, writeregM, writeregW  in  5 each  destination register per stage.
- regwriteE, regwriteM, regwriteW  in  1 each  register write enable per stage.
- memtoregE  in  1  EX instruction is a load.
- pcsrcE  in  1  taken branch/jump resolved in EX.
- mdstartE  in  1  EX instruction is mult/div.
- memreqM  in  1  load/store in MEM.
- memreadyM  in  1  memory completes the access this cycle.
- stallF, stallD, stallE, stallM  out  1 each  hold the corresponding pipeline register.
- flushD, flushE, flushW  out  1 each  clear the IF/ID, ID/EX, MEM/WB register to a bubble.
- forwardAE, forwardBE  out  2 each  forwarding select: 00 regfile, 10 MEM ALU result, 01 WB result.
- md_busy  out  1  mult/div sequencer running.
- md_done  out  1  one-cycle pulse on the final mult/div cycle.
- mem_timeout  out  1  sticky memory timeout error.

Behaviour:
- Reset (reset=0, async): md state MD_IDLE, count 0; mem state M_IDLE, wait count 0; mem_timeout=0.
- All stall/flush/md_done outputs are combinational from registered state and inputs; they read 0 while in reset.

Forwarding (combinational, A shown, B identical with rtE):
- regwriteM && writeregM!=0 && writeregM==rsE -> 10.
- Else regwriteW && writeregW!=0 && writeregW==rsE -> 01.
- Else 00.
- MEM has priority over WB.

Load-use:
- Condition: memtoregE && regwriteE && writeregE!=0 && (writeregE==rsD || writeregE==rtD).
- Response: stallF=stallD=1 and flushE=1 in the same cycle; exactly 1 bubble.

Branch:
- pcsrcE=1 -> flushD=flushE=1 for that cycle; no stall.
- Overrides load-use in the same cycle (no stall, both flushes).

Mult/div FSM:
- MD_IDLE: mdstartE=1 -> stallF/D/E=1 this cycle; load count=MD_CYCLES-1; go MD_RUN.
- MD_RUN: md_busy=1; count decrements each unfrozen cycle; stallF/D/E=1 while count>1.
- count==1 in MD_RUN: stalls drop, md_done=1, go MD_IDLE.
- Net effect: exactly MD_CYCLES-1 stall cycles per op.
- Back-to-back ops: the second op enters EX after the first leaves and restarts the sequence from MD_IDLE.
- Counter is frozen (holds value) while a memory stall is active.

Memory wait FSM:
- M_IDLE: memreqM && !memreadyM -> stallF/D/E/M=1 and flushW=1 this cycle; go M_WAIT; wait count=1.
- M_IDLE: memreqM && memreadyM in the same cycle -> no stall.
- M_WAIT: stalls and flushW held while !memreadyM; wait count increments.
- memreadyM=1 in M_WAIT: stalls drop in that same cycle; go M_IDLE.
- Wait count reaches MEM_TIMEOUT without memreadyM: mem_timeout<=1 (sticky until reset), stalls drop, go M_IDLE, and the access is abandoned.

Priority:
- Order: memory stall > md stall > branch flush > load-use.
- While stallE=1 from mem or md, flushD and flushE are forced to 0 so held registers are not cleared.
- A pending pcsrcE or load-use is re-evaluated when the stall releases.

Reset mid-operation:
- Both FSMs return to idle immediately.
- A partially elapsed md op or memory wait is discarded.

Decomposition:
- Shared package holds:
  - forward-select constants FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01 (same encoding as the existing 3-input mux);
  - MD_IDLE/MD_RUN and M_IDLE/M_WAIT state encodings.
- One sub-module is natural: mem_wait_fsm, which owns the M_IDLE/M_WAIT state, the wait counter and mem_timeout.
- Forwarding, load-use, branch and the md FSM stay in the top module.

Test Plan:
- Forwarding: regwriteM=1, writeregM=8, regwriteW=1, writeregW=8, rsE=8 -> forwardAE=10. Change writeregM to 9 -> forwardAE=01. Set writeregM=writeregW=0 -> forwardAE=00.
- Load-use: memtoregE=1, regwriteE=1, writeregE=5, rtD=5 -> exactly one cycle of stallF=stallD=flushE=1. Add pcsrcE=1 in the same cycle -> flushD=flushE=1 and stallF=0.
- Mult/div: MD_CYCLES=4, mdstartE pulse -> stallE high 3 consecutive cycles, md_busy high 3 cycles starting the cycle after mdstartE, md_done pulses on the 4th cycle.
- Memory wait: memreqM=1 with memreadyM low 3 cycles then high -> stallM and flushW high 3 cycles and low on the ready cycle. memreqM with memreadyM=1 -> no stall.
- Timeout: MEM_TIMEOUT=16, memreadyM held 0 -> stalls release after 16 wait cycles and mem_timeout=1 stays set. Then reset=0 -> mem_timeout=0.
- Overlap/reset: memory stall starts during the 2nd md stall cycle -> md count frozen, total md stall extended by the mem wait length. Assert reset mid-M_WAIT -> all stalls 0 asynchronously, both FSMs idle on release.
